// File: rtl/mmcm_drp_pkg.sv
// Shared definitions for the MMCM DRP reconfiguration sequencer.
package mmcm_drp_pkg;

  localparam int DRP_AW           = 7;
  localparam int DRP_DW           = 16;
  localparam int DEF_DRDY_TIMEOUT = 64;
  localparam int DEF_LOCK_TIMEOUT = 65536;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_ON,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_NEXT,
    S_RST_OFF,
    S_LOCK_WAIT,
    S_DONE
  } state_t;

  // Read-modify-write merge: mask bit 1 keeps the readback bit, 0 takes new data.
  function automatic logic [DRP_DW-1:0] drp_merge(input logic [DRP_DW-1:0] rd,
                                                  input logic [DRP_DW-1:0] mask,
                                                  input logic [DRP_DW-1:0] data);
    return (rd & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/drp_timeout_cnt.sv
// Wait-cycle counter shared by the DRP ready and MMCM lock timeouts.
module drp_timeout_cnt #(
  parameter int CNT_W = 17
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Count cycles spent waiting; load restarts from zero before each wait.
  always_ff @(posedge clk_in) begin
    if (reset || i_load) r_cnt <= '0;
    else if (i_en)       r_cnt <= r_cnt + 1'b1;
  end

  // Expire on the last permitted wait cycle so the caller leaves on the next edge.
  assign o_expire = i_en && (r_cnt == i_limit - 1'b1);

endmodule

// File: rtl/mmcm_drp_sequencer.sv
// Walks a DRP register table with read-modify-write while holding the MMCM
// in reset, then releases reset and waits for lock.
module mmcm_drp_sequencer
  import mmcm_drp_pkg::*;
#(
  parameter int N_ENTRIES    = 4,
  parameter int DRDY_TIMEOUT = DEF_DRDY_TIMEOUT,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int TCQ          = 1
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        cfg_start,
  input  logic [DRP_AW*N_ENTRIES-1:0] entry_addr,
  input  logic [DRP_DW*N_ENTRIES-1:0] entry_mask,
  input  logic [DRP_DW*N_ENTRIES-1:0] entry_data,
  output logic                        cfg_busy,
  output logic                        cfg_done,
  output logic                        cfg_err,
  output logic                        mmcm_rst,
  output logic                        drp_den,
  output logic                        drp_dwe,
  output logic [DRP_AW-1:0]           drp_daddr,
  output logic [DRP_DW-1:0]           drp_di,
  input  logic [DRP_DW-1:0]           drp_do,
  input  logic                        drp_drdy,
  input  logic                        mmcm_locked
);

  localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  // TCQ is a zero-cost interface parameter here: state updates are modelled
  // without clock-to-q delay, so it only gets a sanity check.
  if (N_ENTRIES < 1 || N_ENTRIES > 8) begin : g_bad_entries
    $error("N_ENTRIES must be 1..8");
  end
  if (TCQ < 0 || DRDY_TIMEOUT < 1 || DRDY_TIMEOUT > LOCK_TIMEOUT) begin : g_bad_params
    $error("invalid TCQ or timeout parameters");
  end

  state_t            r_state, w_nxt;
  logic [IW-1:0]     r_idx;
  logic [DRP_DW-1:0] r_new;
  logic              r_err;
  logic [DRP_AW-1:0] w_addr;
  logic [DRP_DW-1:0] w_mask, w_data;
  logic              w_last, w_wait, w_ack, w_expire, w_timeout;
  logic [CW-1:0]     w_limit;

  assign w_addr = entry_addr[DRP_AW*r_idx +: DRP_AW];
  assign w_mask = entry_mask[DRP_DW*r_idx +: DRP_DW];
  assign w_data = entry_data[DRP_DW*r_idx +: DRP_DW];
  assign w_last = (r_idx == IW'(N_ENTRIES - 1));

  // A response in the same cycle as expiry wins over the timeout.
  assign w_wait    = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT) || (r_state == S_LOCK_WAIT);
  assign w_ack     = (r_state == S_LOCK_WAIT) ? mmcm_locked : drp_drdy;
  assign w_limit   = (r_state == S_LOCK_WAIT) ? CW'(LOCK_TIMEOUT) : CW'(DRDY_TIMEOUT);
  assign w_timeout = w_expire && !w_ack;

  drp_timeout_cnt #(.CNT_W(CW)) u_tmo (
    .clk_in   (clk_in),
    .reset    (reset),
    .i_load   (!w_wait),
    .i_en     (w_wait),
    .i_limit  (w_limit),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (cfg_start) w_nxt = S_RST_ON;
      S_RST_ON:    w_nxt = S_RD_REQ;
      S_RD_REQ:    w_nxt = S_RD_WAIT;
      S_RD_WAIT:   if (drp_drdy) w_nxt = S_WR_REQ;
                   else if (w_timeout) w_nxt = S_IDLE;
      S_WR_REQ:    w_nxt = S_WR_WAIT;
      S_WR_WAIT:   if (drp_drdy) w_nxt = S_NEXT;
                   else if (w_timeout) w_nxt = S_IDLE;
      S_NEXT:      w_nxt = w_last ? S_RST_OFF : S_RD_REQ;
      S_RST_OFF:   w_nxt = S_LOCK_WAIT;
      S_LOCK_WAIT: if (mmcm_locked) w_nxt = S_DONE;
                   else if (w_timeout) w_nxt = S_IDLE;
      S_DONE:      w_nxt = S_IDLE;
      default:     w_nxt = S_IDLE;
    endcase
  end

  // Table index, merged write value and sticky error.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_idx <= '0;
      r_new <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE && cfg_start) begin
        r_idx <= '0;
        r_err <= 1'b0;
      end
      if (r_state == S_RD_WAIT && drp_drdy) r_new <= drp_merge(drp_do, w_mask, w_data);
      if (r_state == S_NEXT && !w_last)     r_idx <= r_idx + 1'b1;
      if (w_timeout)                        r_err <= 1'b1;
    end
  end

  // Output decode; the DRP bus is zeroed whenever no access is issued.
  always_comb begin
    cfg_busy  = (r_state != S_IDLE);
    cfg_done  = (r_state == S_DONE);
    cfg_err   = r_err;
    mmcm_rst  = 1'b0;
    drp_den   = 1'b0;
    drp_dwe   = 1'b0;
    drp_daddr = '0;
    drp_di    = '0;
    unique case (r_state)
      S_RST_ON, S_RD_WAIT, S_WR_WAIT, S_NEXT: mmcm_rst = 1'b1;
      S_RD_REQ: begin
        mmcm_rst  = 1'b1;
        drp_den   = 1'b1;
        drp_daddr = w_addr;
      end
      S_WR_REQ: begin
        mmcm_rst  = 1'b1;
        drp_den   = 1'b1;
        drp_dwe   = 1'b1;
        drp_daddr = w_addr;
        drp_di    = r_new;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Scoreboard bench for mmcm_drp_sequencer: DRP slave and MMCM lock models,
// table-level reference model feeding expected accesses and outcomes.
module tb_mmcm_drp_sequencer;

  localparam int N  = 4;
  localparam int DT = 64;
  localparam int LT = 65536;

  logic            clk_in = 1'b0;
  logic            reset = 1'b1;
  logic            cfg_start = 1'b0;
  logic [7*N-1:0]  entry_addr = '0;
  logic [16*N-1:0] entry_mask = '0;
  logic [16*N-1:0] entry_data = '0;
  logic            cfg_busy, cfg_done, cfg_err, mmcm_rst, drp_den, drp_dwe;
  logic [6:0]      drp_daddr;
  logic [15:0]     drp_di;
  logic [15:0]     drp_do = 16'hA5A5;
  logic            drp_drdy = 1'b0;
  logic            mmcm_locked = 1'b0;

  mmcm_drp_sequencer #(.N_ENTRIES(N), .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)) dut (
    .clk_in(clk_in), .reset(reset), .cfg_start(cfg_start),
    .entry_addr(entry_addr), .entry_mask(entry_mask), .entry_data(entry_data),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .mmcm_rst(mmcm_rst),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .mmcm_locked(mmcm_locked)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { bit we; bit [6:0] addr; bit [15:0] di; } acc_t;
  typedef struct { int kind; int refsel; int dly; } end_t; // kind 1=done 2=err; refsel 1=den 2=rst fall

  acc_t exp_acc[$];
  end_t exp_end[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, last_den = 0, rst_fall = 0;
  bit   rst_d = 1'b0, err_d = 1'b0;
  int   drop_at = -1;
  bit   lock_hold = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // DRP slave: drdy three cycles after den, optionally never answering one access.
  int dcnt = 0, acc_n = 0;
  always @(negedge clk_in) begin
    drp_drdy = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) drp_drdy = 1'b1;
    end
    if (!cfg_busy) acc_n = 0;
    if (drp_den) begin
      if (acc_n != drop_at) dcnt = 3;
      acc_n++;
    end
  end

  // MMCM lock: lost in reset, regained 100 cycles after release unless held off.
  int lcnt = 0;
  always @(negedge clk_in) begin
    if (mmcm_rst || lock_hold) begin
      mmcm_locked = 1'b0;
      lcnt = 0;
    end else if (lcnt >= 100) mmcm_locked = 1'b1;
    else lcnt++;
  end

  // Monitor: pops expectations whenever the DUT presents an access or outcome.
  always @(negedge clk_in) begin
    acc_t a;
    end_t e;
    cyc++;
    if (drp_den) begin
      last_den = cyc;
      if (exp_acc.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_access actual=addr %0h we %0b expected=none", drp_daddr, drp_dwe);
      end else begin
        a = exp_acc.pop_front();
        chk("drp_dwe", 32'(drp_dwe), 32'(a.we));
        chk("drp_daddr", 32'(drp_daddr), 32'(a.addr));
        chk("drp_di", 32'(drp_di), 32'(a.di));
        chk("mmcm_rst_during_drp", 32'(mmcm_rst), 32'd1);
      end
    end else chk("bus_zero_when_idle", 32'({drp_daddr, drp_di}), 32'd0);
    if (!mmcm_rst && rst_d) rst_fall = cyc;
    rst_d = mmcm_rst;
    if (cfg_done || (cfg_err && !err_d)) begin
      if (exp_end.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_outcome actual=done %0b err %0b expected=none", cfg_done, cfg_err);
      end else begin
        e = exp_end.pop_front();
        chk("outcome_kind", cfg_done ? 32'd1 : 32'd2, 32'(e.kind));
        if (e.refsel == 1) chk("drdy_timeout_latency", 32'(cyc - last_den), 32'(e.dly));
        if (e.refsel == 2) chk("lock_timeout_latency", 32'(cyc - rst_fall), 32'(e.dly));
        if (e.kind == 2)   chk("mmcm_rst_low_on_err", 32'(mmcm_rst), 32'd0);
      end
    end
    err_d = cfg_err;
  end

  // Reference model: the table as a list of read/write accesses and one outcome.
  function automatic void build_expect(input int drop, input bit hold);
    acc_t a;
    end_t e;
    logic [15:0] m, d;
    for (int i = 0; i < N; i++) begin
      a.we = 1'b0; a.addr = entry_addr[7*i +: 7]; a.di = '0;
      exp_acc.push_back(a);
      if (drop == 2*i) begin e = '{2, 1, DT + 1}; exp_end.push_back(e); return; end
      m = entry_mask[16*i +: 16];
      d = entry_data[16*i +: 16];
      a.we = 1'b1; a.di = (drp_do & m) | (d & ~m);
      exp_acc.push_back(a);
      if (drop == 2*i + 1) begin e = '{2, 1, DT + 1}; exp_end.push_back(e); return; end
    end
    if (hold) e = '{2, 2, LT + 1};
    else      e = '{1, 0, 0};
    exp_end.push_back(e);
  endfunction

  task automatic rand_table();
    for (int i = 0; i < N; i++) begin
      entry_addr[7*i +: 7]   = 7'($urandom);
      entry_mask[16*i +: 16] = 16'($urandom);
      entry_data[16*i +: 16] = 16'($urandom);
    end
    drp_do = 16'($urandom);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(cfg_busy), 0);
    chk({tag, "_done"}, 32'(cfg_done), 0);
    chk({tag, "_err"}, 32'(cfg_err), 0);
    chk({tag, "_mmcm_rst"}, 32'(mmcm_rst), 0);
    chk({tag, "_den"}, 32'(drp_den), 0);
    chk({tag, "_dwe"}, 32'(drp_dwe), 0);
    chk({tag, "_daddr"}, 32'(drp_daddr), 0);
    chk({tag, "_di"}, 32'(drp_di), 0);
  endtask

  task automatic run_seq(input int drop, input bit hold, input bit inject, input int budget);
    int n;
    drop_at = drop;
    lock_hold = hold;
    build_expect(drop, hold);
    cfg_start = 1'b1;
    @(negedge clk_in);
    cfg_start = 1'b0;
    chk("err_cleared_on_start", 32'(cfg_err), 0);
    chk("busy_after_start", 32'(cfg_busy), 1);
    chk("mmcm_rst_after_start", 32'(mmcm_rst), 1);
    if (inject) begin
      n = 0;
      while (!(drp_den && drp_dwe) && n < 200) begin @(negedge clk_in); n++; end
      chk("reached_write", 32'(drp_den && drp_dwe), 1);
      @(negedge clk_in);
      cfg_start = 1'b1;
      @(negedge clk_in);
      cfg_start = 1'b0;
    end
    n = 0;
    while (cfg_busy && n < budget) begin @(negedge clk_in); n++; end
    chk("sequence_finished", 32'(cfg_busy), 0);
    repeat (6) @(negedge clk_in);
    chk("accesses_drained", 32'(exp_acc.size()), 0);
    chk("outcomes_drained", 32'(exp_end.size()), 0);
    chk("final_err", 32'(cfg_err), 32'(hold || drop >= 0));
    chk("final_mmcm_rst", 32'(mmcm_rst), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    acc_t a;
    int   n;
    repeat (3) @(negedge clk_in);
    check_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    check_zero("post_reset_idle");

    // Directed merge: readback A5A5, keep top nibble, new 0123 -> A123.
    rand_table();
    drp_do = 16'hA5A5;
    entry_mask[15:0] = 16'hF000;
    entry_data[15:0] = 16'h0123;
    run_seq(-1, 1'b0, 1'b0, 500);

    // Randomised tables.
    for (int k = 0; k < 4; k++) begin
      rand_table();
      run_seq(-1, 1'b0, 1'b0, 500);
    end

    // No drdy on entry 1 read.
    rand_table();
    run_seq(2, 1'b0, 1'b0, 500);

    // cfg_start during WR_WAIT is ignored.
    rand_table();
    run_seq(-1, 1'b0, 1'b1, 500);

    // Reset during RD_WAIT; the late drdy must not restart anything.
    rand_table();
    drop_at = -1;
    a.we = 1'b0; a.addr = entry_addr[6:0]; a.di = '0;
    exp_acc.push_back(a);
    cfg_start = 1'b1;
    @(negedge clk_in);
    cfg_start = 1'b0;
    n = 0;
    while (!drp_den && n < 50) begin @(negedge clk_in); n++; end
    chk("reached_read", 32'(drp_den), 1);
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    check_zero("reset_in_rd_wait");
    exp_acc.delete();
    exp_end.delete();
    repeat (8) @(negedge clk_in);
    check_zero("after_late_drdy");

    // Lock never arrives, then a clean rerun clears the error.
    rand_table();
    run_seq(-1, 1'b1, 1'b0, 70000);
    chk("err_sticky_before_rerun", 32'(cfg_err), 1);
    run_seq(-1, 1'b0, 1'b0, 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
